hazard_ctrl_unit: RTL and testbench

Second-generation hazard controller for the 5-stage RV32I pipeline, replacing the stall-only detector. Parametrised by forwarding mode: it either stalls on any RAW dependency, or forwards from MEM and WB and stalls only on load-use. It also freezes the whole pipeline while the LSU handshake is pending, with a timeout watchdog. Saturating counters record stall and flush cycles. It sits between the pipeline registers and the ID/EX operand muxes.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_ctrl_unit.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared types for the hazard controller: forwarding-mux select
//           codes and controller FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Operand-mux select driven to the ID/EX operand muxes
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,   // value already captured in ID/EX
    FWD_MEM = 2'b01,   // ALU result sitting in EX/MEM
    FWD_WB  = 2'b10    // write-back data
  } fwd_sel_e;

  // Controller state
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : W-bit up counter that sticks at all-ones.
// Ports   : clk      in  1  clock
//           clear_n  in  1  synchronous active-low clear
//           en       in  1  count this cycle
//           count    out W  current value
// Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_unit
// Purpose : Hazard controller for the 5-stage RV32I pipeline. Detects RAW
//           hazards (stall-only or forwarding + load-use mode), drives the
//           operand forwarding selects, freezes the pipe while an LSU access
//           is outstanding (with a timeout watchdog) and keeps saturating
//           stall / flush cycle counters.
// Ports   : i_clk, i_reset (sync, active-low)
//           i_rs{1,2}_addr_id, i_rs{1,2}_used_id   ID-stage sources
//           i_rs{1,2}_addr_ex                      EX-stage sources
//           i_rd_addr_{ex,mem,wb}, i_rd_wren_*     in-flight destinations
//           i_is_load_{ex,mem}, i_branch_taken, i_mem_req, i_mem_ack
//           o_stall_{pc,if_id,id_ex,ex_mem}        hold pipeline registers
//           o_flush_{if_id,id_ex}                  insert bubbles
//           o_fwd_{a,b}_sel                        operand mux selects
//           o_mem_timeout                          sticky LSU timeout
//           o_stall_cnt, o_flush_cnt               saturating perf counters
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_rs1_addr_id,
  input  logic [REG_AW-1:0] i_rs2_addr_id,
  input  logic              i_rs1_used_id,
  input  logic              i_rs2_used_id,
  input  logic [REG_AW-1:0] i_rs1_addr_ex,
  input  logic [REG_AW-1:0] i_rs2_addr_ex,
  input  logic [REG_AW-1:0] i_rd_addr_ex,
  input  logic [REG_AW-1:0] i_rd_addr_mem,
  input  logic [REG_AW-1:0] i_rd_addr_wb,
  input  logic              i_rd_wren_ex,
  input  logic              i_rd_wren_mem,
  input  logic              i_rd_wren_wb,
  input  logic              i_is_load_ex,
  input  logic              i_is_load_mem,
  input  logic              i_branch_taken,
  input  logic              i_mem_req,
  input  logic              i_mem_ack,
  output logic              o_stall_pc,
  output logic              o_stall_if_id,
  output logic              o_stall_id_ex,
  output logic              o_stall_ex_mem,
  output logic              o_flush_if_id,
  output logic              o_flush_id_ex,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic              o_mem_timeout,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  // Counter must hold values up to MEM_TIMEOUT
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;
  logic              data_stall;
  fwd_sel_e          fwd_a, fwd_b;
  logic              id1_ex_hit, id2_ex_hit;

  // A producer only matters if it really writes, is not x0, and the
  // consumer really reads that register.
  function automatic logic hit(input logic              wren,
                               input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs,
                               input logic              used);
    return wren && (rd != '0) && (rd == rs) && used;
  endfunction

  assign id1_ex_hit = hit(i_rd_wren_ex, i_rd_addr_ex, i_rs1_addr_id, i_rs1_used_id);
  assign id2_ex_hit = hit(i_rd_wren_ex, i_rd_addr_ex, i_rs2_addr_id, i_rs2_used_id);

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Only a load in EX cannot be forwarded in time.
      assign data_stall = (id1_ex_hit || id2_ex_hit) && i_is_load_ex;

      // MEM is younger than WB, so it wins. A load in MEM has no data yet
      // on the ALU-result path; the load-use stall already covered it.
      always_comb begin
        fwd_a = FWD_RF;
        if (hit(i_rd_wren_mem, i_rd_addr_mem, i_rs1_addr_ex, 1'b1) && !i_is_load_mem)
          fwd_a = FWD_MEM;
        else if (hit(i_rd_wren_wb, i_rd_addr_wb, i_rs1_addr_ex, 1'b1))
          fwd_a = FWD_WB;
      end

      always_comb begin
        fwd_b = FWD_RF;
        if (hit(i_rd_wren_mem, i_rd_addr_mem, i_rs2_addr_ex, 1'b1) && !i_is_load_mem)
          fwd_b = FWD_MEM;
        else if (hit(i_rd_wren_wb, i_rd_addr_wb, i_rs2_addr_ex, 1'b1))
          fwd_b = FWD_WB;
      end
    end else begin : g_stall_only
      logic id1_mem_hit, id2_mem_hit;
      assign id1_mem_hit = hit(i_rd_wren_mem, i_rd_addr_mem, i_rs1_addr_id, i_rs1_used_id);
      assign id2_mem_hit = hit(i_rd_wren_mem, i_rd_addr_mem, i_rs2_addr_id, i_rs2_used_id);
      // WB needs no stall: the register file is write-first.
      assign data_stall = id1_ex_hit || id2_ex_hit || id1_mem_hit || id2_mem_hit;
      assign fwd_a      = FWD_RF;
      assign fwd_b      = FWD_RF;
    end
  endgenerate

  // State register and wait counter
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

  // Next state and pipeline control
  always_comb begin
    state_nxt      = state;
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_stall_id_ex  = 1'b0;
    o_stall_ex_mem = 1'b0;
    o_flush_if_id  = 1'b0;
    o_flush_id_ex  = 1'b0;
    freeze         = (i_mem_req && !i_mem_ack) || (state == ERROR);

    unique case (state)
      RUN: begin
        if (i_mem_req && !i_mem_ack) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        // wait_cnt holds the number of earlier MEM_WAIT cycles, so this is
        // the MEM_TIMEOUT-th unacked one.
        if (i_mem_ack)
          state_nxt = RUN;
        else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
          state_nxt = ERROR;
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = RUN;
    endcase

    if (i_reset) begin
      if (freeze) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_stall_id_ex  = 1'b1;
        o_stall_ex_mem = 1'b1;
      end else if (i_branch_taken) begin
        // The branch stays in EX across a freeze, so it is honoured here on
        // the first unfrozen cycle without being remembered.
        o_flush_if_id  = 1'b1;
        o_flush_id_ex  = 1'b1;
      end else if (data_stall) begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_flush_id_ex  = 1'b1;
      end
    end
  end

  assign o_fwd_a_sel   = i_reset ? fwd_a : FWD_RF;
  assign o_fwd_b_sel   = i_reset ? fwd_b : FWD_RF;
  assign o_mem_timeout = (state == ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (i_clk),
    .clear_n (i_reset),
    .en      (o_stall_pc),
    .count   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (i_clk),
    .clear_n (i_reset),
    .en      (o_flush_if_id),
    .count   (o_flush_cnt)
  );

endmodule : hazard_ctrl_unit
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl_unit
// Purpose : Self-checking bench. Two controllers share one stimulus stream:
//           u_a (forwarding, MEM_TIMEOUT=255, 32-bit counters) and
//           u_b (stall-only, MEM_TIMEOUT=3, 4-bit counters so saturation
//           is reached). Both are compared every cycle with a reference
//           model written from the pipeline rules.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic          used1, used2, wr_ex, wr_mem, wr_wb, ld_ex, ld_mem, br, req, ack;

  logic        a_spc, a_sif, a_sid, a_sex, a_fif, a_fid, a_to;
  logic [1:0]  a_sa, a_sb;
  logic [31:0] a_sc, a_fc;
  logic        b_spc, b_sif, b_sid, b_sex, b_fif, b_fid, b_to;
  logic [1:0]  b_sa, b_sb;
  logic [3:0]  b_sc, b_fc;

  hazard_ctrl_unit #(.REG_AW(AW), .FWD_EN(1), .MEM_TIMEOUT(255), .CNT_W(32)) u_a (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_addr_id(rs1_id), .i_rs2_addr_id(rs2_id),
    .i_rs1_used_id(used1), .i_rs2_used_id(used2),
    .i_rs1_addr_ex(rs1_ex), .i_rs2_addr_ex(rs2_ex),
    .i_rd_addr_ex(rd_ex), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
    .i_rd_wren_ex(wr_ex), .i_rd_wren_mem(wr_mem), .i_rd_wren_wb(wr_wb),
    .i_is_load_ex(ld_ex), .i_is_load_mem(ld_mem), .i_branch_taken(br),
    .i_mem_req(req), .i_mem_ack(ack),
    .o_stall_pc(a_spc), .o_stall_if_id(a_sif), .o_stall_id_ex(a_sid),
    .o_stall_ex_mem(a_sex), .o_flush_if_id(a_fif), .o_flush_id_ex(a_fid),
    .o_fwd_a_sel(a_sa), .o_fwd_b_sel(a_sb), .o_mem_timeout(a_to),
    .o_stall_cnt(a_sc), .o_flush_cnt(a_fc)
  );

  hazard_ctrl_unit #(.REG_AW(AW), .FWD_EN(0), .MEM_TIMEOUT(3), .CNT_W(4)) u_b (
    .i_clk(clk), .i_reset(rst_n),
    .i_rs1_addr_id(rs1_id), .i_rs2_addr_id(rs2_id),
    .i_rs1_used_id(used1), .i_rs2_used_id(used2),
    .i_rs1_addr_ex(rs1_ex), .i_rs2_addr_ex(rs2_ex),
    .i_rd_addr_ex(rd_ex), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
    .i_rd_wren_ex(wr_ex), .i_rd_wren_mem(wr_mem), .i_rd_wren_wb(wr_wb),
    .i_is_load_ex(ld_ex), .i_is_load_mem(ld_mem), .i_branch_taken(br),
    .i_mem_req(req), .i_mem_ack(ack),
    .o_stall_pc(b_spc), .o_stall_if_id(b_sif), .o_stall_id_ex(b_sid),
    .o_stall_ex_mem(b_sex), .o_flush_if_id(b_fif), .o_flush_id_ex(b_fid),
    .o_fwd_a_sel(b_sa), .o_fwd_b_sel(b_sb), .o_mem_timeout(b_to),
    .o_stall_cnt(b_sc), .o_flush_cnt(b_fc)
  );

  // Packed view: {stall pc,if_id,id_ex,ex_mem, flush if_id,id_ex, sel a, sel b, timeout}
  wire [10:0] a_vec = {a_spc, a_sif, a_sid, a_sex, a_fif, a_fid, a_sa, a_sb, a_to};
  wire [10:0] b_vec = {b_spc, b_sif, b_sid, b_sex, b_fif, b_fid, b_sa, b_sb, b_to};

  // ---------------- reference model ----------------
  int     P_FWD [2] = '{1, 0};
  int     P_TO  [2] = '{255, 3};
  longint P_MAX [2] = '{64'hFFFF_FFFF, 64'd15};

  bit     m_err  [2];   // watchdog fired
  bit     m_wait [2];   // an LSU access is outstanding
  int     m_n    [2];   // unacked cycles spent waiting so far
  longint m_sc   [2];
  longint m_fc   [2];

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
  endtask

  function automatic logic writes(input logic w, input logic [AW-1:0] rd,
                                  input logic [AW-1:0] rs, input logic u);
    return w && (rd != 0) && (rd == rs) && u;
  endfunction

  function automatic logic [1:0] pick(input logic [AW-1:0] rs);
    if (writes(wr_mem, rd_mem, rs, 1'b1) && !ld_mem) return 2'b01;
    if (writes(wr_wb, rd_wb, rs, 1'b1)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [10:0] expect_out(input int k);
    logic frz, ds, ex_dep, mem_dep;
    logic [5:0] ctl;
    logic [1:0] sa, sb;
    ex_dep  = writes(wr_ex, rd_ex, rs1_id, used1) || writes(wr_ex, rd_ex, rs2_id, used2);
    mem_dep = writes(wr_mem, rd_mem, rs1_id, used1) || writes(wr_mem, rd_mem, rs2_id, used2);
    ds  = (P_FWD[k] != 0) ? (ex_dep && ld_ex) : (ex_dep || mem_dep);
    frz = (req && !ack) || m_err[k];
    sa  = (P_FWD[k] != 0) ? pick(rs1_ex) : 2'b00;
    sb  = (P_FWD[k] != 0) ? pick(rs2_ex) : 2'b00;
    if (!rst_n)     begin ctl = 6'b0000_00; sa = 2'b00; sb = 2'b00; end
    else if (frz)   ctl = 6'b1111_00;
    else if (br)    ctl = 6'b0000_11;
    else if (ds)    ctl = 6'b1100_01;
    else            ctl = 6'b0000_00;
    return {ctl, sa, sb, m_err[k]};
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [10:0] e;
      e = expect_out(k);
      if (!rst_n) begin
        m_err[k] = 0; m_wait[k] = 0; m_n[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        if (e[10] && m_sc[k] < P_MAX[k]) m_sc[k]++;
        if (e[6]  && m_fc[k] < P_MAX[k]) m_fc[k]++;
        if (m_err[k]) begin
          // only reset clears it
        end else if (m_wait[k]) begin
          if (ack) begin
            m_wait[k] = 0; m_n[k] = 0;
          end else begin
            m_n[k]++;
            if (m_n[k] == P_TO[k]) begin m_err[k] = 1; m_wait[k] = 0; end
          end
        end else if (req && !ack) begin
          m_wait[k] = 1; m_n[k] = 0;
        end
      end
    end
  endtask

  // One clock: compare mid-cycle, then advance both DUT and model.
  task automatic cycle();
    #2;
    check_eq("a.ctl", 64'(a_vec), 64'(expect_out(0)));
    check_eq("a.stall_cnt", 64'(a_sc), 64'(m_sc[0]));
    check_eq("a.flush_cnt", 64'(a_fc), 64'(m_fc[0]));
    check_eq("b.ctl", 64'(b_vec), 64'(expect_out(1)));
    check_eq("b.stall_cnt", 64'(b_sc), 64'(m_sc[1]));
    check_eq("b.flush_cnt", 64'(b_fc), 64'(m_fc[1]));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst_n = 1; rs1_id = 0; rs2_id = 0; rs1_ex = 0; rs2_ex = 0;
    rd_ex = 0; rd_mem = 0; rd_wb = 0; used1 = 0; used2 = 0;
    wr_ex = 0; wr_mem = 0; wr_wb = 0; ld_ex = 0; ld_mem = 0;
    br = 0; req = 0; ack = 0;
  endtask

  task automatic rand_inputs();
    rs1_id = AW'($urandom_range(0, 3)); rs2_id = AW'($urandom_range(0, 3));
    rs1_ex = AW'($urandom_range(0, 3)); rs2_ex = AW'($urandom_range(0, 3));
    rd_ex  = AW'($urandom_range(0, 3)); rd_mem = AW'($urandom_range(0, 3));
    rd_wb  = AW'($urandom_range(0, 3));
    used1 = 1'($urandom_range(0, 1)); used2 = 1'($urandom_range(0, 1));
    wr_ex = 1'($urandom_range(0, 1)); wr_mem = 1'($urandom_range(0, 1));
    wr_wb = 1'($urandom_range(0, 1));
    ld_ex = 1'($urandom_range(0, 1)); ld_mem = 1'($urandom_range(0, 1));
    br    = ($urandom_range(0, 4) == 0);
    req   = ($urandom_range(0, 2) == 0);
    ack   = ($urandom_range(0, 2) == 0);
    rst_n = ($urandom_range(0, 39) != 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_wait[k] = 0; m_n[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
    #1;
    // Reset still low: outputs forced quiet
    br = 1; req = 1; rs1_id = 2; used1 = 1; rd_ex = 2; wr_ex = 1;
    cycle();
    idle(); cycle();

    // Load-use: lw x5 in EX, ID reads x5
    idle(); rs1_id = 5; used1 = 1; rs2_id = 1; used2 = 1; rd_ex = 5; wr_ex = 1; ld_ex = 1;
    cycle();
    idle(); rs1_id = 5; used1 = 1; rd_mem = 5; wr_mem = 1; ld_mem = 1;
    cycle();
    idle(); rs1_ex = 5; rd_wb = 5; wr_wb = 1;
    cycle();

    // MEM beats WB on x3, then x0 is never forwarded
    idle(); rs1_ex = 3; rs2_ex = 3; rd_mem = 3; wr_mem = 1; rd_wb = 3; wr_wb = 1;
    cycle();
    idle(); rs1_ex = 0; rs2_ex = 0; rd_mem = 0; wr_mem = 1; rd_wb = 0; wr_wb = 1;
    cycle();

    // MEM-stage producer of x7, ID reads it (stall-only unit stalls one cycle)
    idle(); rs2_id = 7; used2 = 1; rd_mem = 7; wr_mem = 1;
    cycle();
    idle(); rs2_id = 7; used2 = 1; rd_wb = 7; wr_wb = 1;
    cycle();

    // LSU wait of 4 cycles with a branch pending, ack on the 5th
    idle(); rst_n = 0; cycle();
    for (int i = 0; i < 4; i++) begin
      idle(); req = 1; br = 1; cycle();
    end
    idle(); req = 1; ack = 1; br = 1; cycle();
    idle(); cycle();

    // Same-cycle ack: no freeze
    idle(); req = 1; ack = 1; cycle();

    // Watchdog: never acked, then reset recovers
    idle(); rst_n = 0; cycle();
    for (int i = 0; i < 6; i++) begin
      idle(); req = 1; cycle();
    end
    idle(); cycle();
    idle(); rst_n = 0; cycle();
    idle(); cycle();

    // Data stall together with a branch: branch wins
    idle(); rs1_id = 5; used1 = 1; rd_ex = 5; wr_ex = 1; ld_ex = 1; br = 1;
    cycle();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_hazard_ctrl_unit
`default_nettype wire
